// File: rtl/rx_seq_pkg.sv
// rx_seq_pkg: shared constants, state encoding and helpers for the RX frame sequencer
package rx_seq_pkg;
  localparam int MAC_WIDTH   = 64;
  localparam int TKEEP_WIDTH = 8;
  localparam int NUM_BUFS    = 4;
  localparam int BUF_WORDS   = 192;
  localparam int BUF_IDX_W   = $clog2(NUM_BUFS);
  localparam int WORD_IDX_W  = $clog2(BUF_WORDS + 1);
  localparam int ADDR_W      = BUF_IDX_W + WORD_IDX_W;
  localparam int LEN_W       = $clog2(BUF_WORDS * TKEEP_WIDTH + 1);
  localparam int CNT_W       = 16;
  localparam int KEEP_LSB    = 0;
  typedef enum logic [1:0] {IDLE, RECV, DROP, COMMIT} state_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/rx_buf_allocator.sv
// rx_buf_allocator: busy bitmap of frame buffers with lowest-index-first allocation
//   alloc_i      marks the currently offered index busy
//   free_mask_i  one-hot (or multi-hot) set of indices returned to the pool
//   any_free_o   at least one buffer is free
//   alloc_idx_o  lowest free index, valid when any_free_o
module rx_buf_allocator #(
  parameter int NUM_BUFS = 4,
  parameter int BW = $clog2(NUM_BUFS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc_i,
  input  logic [NUM_BUFS-1:0] free_mask_i,
  output logic                any_free_o,
  output logic [BW-1:0]       alloc_idx_o
);
  logic [NUM_BUFS-1:0] busy_q;
  always_comb begin
    alloc_idx_o = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) alloc_idx_o = busy_q[i] ? alloc_idx_o : BW'(i);
    any_free_o = ~&busy_q;
  end
  // allocation wins over a free of the same (already free) index
  always_ff @(posedge clk or posedge reset)
    if (reset) busy_q <= '0;
    else busy_q <= (busy_q & ~free_mask_i) | (alloc_i ? NUM_BUFS'(1) << alloc_idx_o : '0);
endmodule

// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer: moves RX FIFO words into pooled frame buffers and issues frame descriptors
//   RX_FIFO_pipe_read_data/ack/req  FIFO pop interface {last, data, keep}
//   buf_wr_en/addr/data             buffer RAM write port, addr = {buf, word}
//   desc_valid/buf/len, desc_ready  completed-frame descriptor handshake
//   free_valid/free_index           host returns a buffer to the pool
//   good/bad/oversize_count         saturating frame statistics
module rx_frame_sequencer #(
  parameter int MAC_WIDTH   = rx_seq_pkg::MAC_WIDTH,
  parameter int TKEEP_WIDTH = rx_seq_pkg::TKEEP_WIDTH,
  parameter int NUM_BUFS    = rx_seq_pkg::NUM_BUFS,
  parameter int BUF_WORDS   = rx_seq_pkg::BUF_WORDS
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [MAC_WIDTH+TKEEP_WIDTH:0]         RX_FIFO_pipe_read_data,
  input  logic                                   RX_FIFO_pipe_read_ack,
  output logic                                   RX_FIFO_pipe_read_req,
  output logic                                   buf_wr_en,
  output logic [rx_seq_pkg::ADDR_W-1:0]          buf_wr_addr,
  output logic [MAC_WIDTH+TKEEP_WIDTH-1:0]       buf_wr_data,
  output logic                                   desc_valid,
  output logic [rx_seq_pkg::BUF_IDX_W-1:0]       desc_buf,
  output logic [rx_seq_pkg::LEN_W-1:0]           desc_len,
  input  logic                                   desc_ready,
  input  logic                                   free_valid,
  input  logic [rx_seq_pkg::BUF_IDX_W-1:0]       free_index,
  output logic [rx_seq_pkg::CNT_W-1:0]           good_count,
  output logic [rx_seq_pkg::CNT_W-1:0]           bad_count,
  output logic [rx_seq_pkg::CNT_W-1:0]           oversize_count
);
  import rx_seq_pkg::*;
  state_t state_q;
  logic [BUF_IDX_W-1:0] buf_q, cur_buf, alloc_idx;
  logic [WORD_IDX_W-1:0] word_q, cur_word;
  logic [TKEEP_WIDTH-1:0] keep;
  logic [LEN_W-1:0] pop, len;
  logic [NUM_BUFS-1:0] free_mask;
  logic xfer, last, bad, full, alloc, rel, any_free;
  rx_buf_allocator #(.NUM_BUFS(NUM_BUFS), .BW(BUF_IDX_W)) u_alloc (
    .clk(clk),
    .reset(reset),
    .alloc_i(alloc),
    .free_mask_i(free_mask),
    .any_free_o(any_free),
    .alloc_idx_o(alloc_idx)
  );
  always_comb begin
    last = RX_FIFO_pipe_read_data[MAC_WIDTH+TKEEP_WIDTH];
    keep = RX_FIFO_pipe_read_data[KEEP_LSB +: TKEEP_WIDTH];
    bad = last & ~|keep;
    full = state_q == RECV & word_q == WORD_IDX_W'(BUF_WORDS);
    RX_FIFO_pipe_read_req = ~reset & (state_q == IDLE ? any_free : state_q != COMMIT);
    xfer = RX_FIFO_pipe_read_req & RX_FIFO_pipe_read_ack;
    cur_buf = state_q == IDLE ? alloc_idx : buf_q;
    cur_word = state_q == IDLE ? '0 : word_q;
    buf_wr_en = xfer & (state_q == IDLE | state_q == RECV) & ~full;
    buf_wr_addr = {cur_buf, cur_word};
    buf_wr_data = RX_FIFO_pipe_read_data[MAC_WIDTH+TKEEP_WIDTH-1:0];
    // a single-word bad marker never claims a buffer
    alloc = xfer & state_q == IDLE & ~bad;
    rel = xfer & (full | (state_q == RECV & bad));
    pop = '0;
    for (int i = 0; i < TKEEP_WIDTH; i++) pop = pop + LEN_W'(keep[i]);
    len = LEN_W'(cur_word) * LEN_W'(TKEEP_WIDTH) + pop;
    free_mask = (free_valid ? NUM_BUFS'(1) << free_index : '0) | (rel ? NUM_BUFS'(1) << buf_q : '0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      buf_q <= '0;
      word_q <= '0;
      desc_valid <= 1'b0;
      desc_buf <= '0;
      desc_len <= '0;
      good_count <= '0;
      bad_count <= '0;
      oversize_count <= '0;
    end else
      case (state_q)
        IDLE, RECV:
          if (xfer) begin
            buf_q <= cur_buf;
            word_q <= cur_word + 1'b1;
            if (full) begin
              oversize_count <= sat_inc(oversize_count);
              state_q <= last ? IDLE : DROP;
            end else if (!last) state_q <= RECV;
            else if (bad) begin
              bad_count <= sat_inc(bad_count);
              state_q <= IDLE;
            end else begin
              desc_valid <= 1'b1;
              desc_buf <= cur_buf;
              desc_len <= len;
              good_count <= sat_inc(good_count);
              state_q <= COMMIT;
            end
          end
        DROP: if (xfer & last) state_q <= IDLE;
        default:
          if (desc_ready) begin
            desc_valid <= 1'b0;
            state_q <= IDLE;
          end
      endcase
endmodule

// File: tb/tb_rx_frame_sequencer.sv
// tb_rx_frame_sequencer: randomized frames checked against a frame-level pool/length model
module tb_rx_frame_sequencer;
  localparam int BW = 192;
  logic clk = 1'b0;
  logic reset, rd_ack, rd_req, wr_en, desc_valid, desc_ready, free_valid;
  logic [72:0] rd_data;
  logic [9:0] wr_addr;
  logic [71:0] wr_data;
  logic [1:0] desc_buf, free_index;
  logic [10:0] desc_len;
  logic [15:0] good_count, bad_count, oversize_count;
  int checks = 0, errors = 0;
  bit busy[4];
  int n_good, n_bad, n_over;
  rx_frame_sequencer dut (
    .clk(clk),
    .reset(reset),
    .RX_FIFO_pipe_read_data(rd_data),
    .RX_FIFO_pipe_read_ack(rd_ack),
    .RX_FIFO_pipe_read_req(rd_req),
    .buf_wr_en(wr_en),
    .buf_wr_addr(wr_addr),
    .buf_wr_data(wr_data),
    .desc_valid(desc_valid),
    .desc_buf(desc_buf),
    .desc_len(desc_len),
    .desc_ready(desc_ready),
    .free_valid(free_valid),
    .free_index(free_index),
    .good_count(good_count),
    .bad_count(bad_count),
    .oversize_count(oversize_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int lowest_free();
    for (int i = 0; i < 4; i++) if (!busy[i]) return i;
    return -1;
  endfunction
  function automatic logic [7:0] keep_of(input int c);
    logic [8:0] t;
    t = (9'd1 << c) - 9'd1;
    return t[7:0];
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 4; i++) busy[i] = 0;
    n_good = 0;
    n_bad = 0;
    n_over = 0;
  endtask
  task automatic chk_counts();
    chk("good_count", good_count, n_good);
    chk("bad_count", bad_count, n_bad);
    chk("oversize_count", oversize_count, n_over);
  endtask
  task automatic chk_reset();
    chk("rst_read_req", rd_req, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_desc_buf", desc_buf, 0);
    chk("rst_desc_len", desc_len, 0);
    chk_counts();
  endtask
  task automatic host_free(input int idx);
    @(negedge clk);
    free_valid = 1'b1;
    free_index = 2'(idx);
    @(negedge clk);
    free_valid = 1'b0;
    busy[idx] = 0;
  endtask
  task automatic stall_check(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rd_ack = 1'b1;
      rd_data = {1'b1, $urandom, $urandom, 8'hff};
      #1;
      chk("stall_read_req", rd_req, 0);
      chk("stall_wr_en", wr_en, 0);
    end
    @(negedge clk);
    rd_ack = 1'b0;
  endtask
  // nw words; last word keeps kc bytes (or zero keep if bad); fidx freed alongside word 0
  task automatic send_frame(input int nw, input int kc, input bit bad, input int fidx, input int hold);
    int b, i, cyc;
    logic [63:0] d;
    logic [7:0] k;
    bit lst;
    b = lowest_free();
    i = 0;
    cyc = 0;
    while (i < nw && cyc < 4000) begin
      @(negedge clk);
      free_valid = 1'b0;
      cyc++;
      rd_ack = $urandom_range(0, 3) != 0;
      lst = i == nw - 1;
      k = lst ? (bad ? 8'h00 : keep_of(kc)) : 8'($urandom);
      d = {$urandom, $urandom};
      rd_data = {lst, d, k};
      if (rd_ack && i == 0 && fidx >= 0) begin
        free_valid = 1'b1;
        free_index = 2'(fidx);
      end
      #1;
      chk("read_req", rd_req, 1);
      chk("wr_en", wr_en, rd_ack && i < BW);
      if (rd_ack && i < BW) begin
        chk("wr_addr", wr_addr, {b[1:0], i[7:0]});
        chk("wr_data", wr_data, {d, k});
      end
      if (rd_ack) begin
        if (i == 0 && fidx >= 0 && fidx != b) busy[fidx] = 0;
        i++;
      end
    end
    if (i < nw) chk("frame_timeout", i, nw);
    @(negedge clk);
    rd_ack = 1'b0;
    free_valid = 1'b0;
    if (nw > BW) n_over++;
    else if (bad) n_bad++;
    else begin
      n_good++;
      busy[b] = 1;
      for (int h = 0; h <= hold; h++) begin
        rd_ack = 1'b1;
        desc_ready = h == hold;
        #1;
        chk("desc_valid", desc_valid, 1);
        chk("desc_buf", desc_buf, b);
        chk("desc_len", desc_len, 8 * (nw - 1) + kc);
        chk("commit_read_req", rd_req, 0);
        chk("commit_wr_en", wr_en, 0);
        @(negedge clk);
      end
      rd_ack = 1'b0;
      desc_ready = 1'b0;
    end
    #1;
    chk("desc_done", desc_valid, 0);
    chk_counts();
  endtask
  initial begin
    int r, nw, words;
    reset = 1'b1;
    rd_ack = 1'b1;
    rd_data = '0;
    desc_ready = 1'b0;
    free_valid = 1'b0;
    free_index = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    reset = 1'b0;
    rd_ack = 1'b0;
    send_frame(3, 4, 0, -1, 0);
    send_frame(2, 8, 0, -1, 1);
    send_frame(1, 3, 0, -1, 0);
    send_frame(4, 5, 0, -1, 2);
    stall_check(5);
    host_free(2);
    send_frame(2, 6, 0, -1, 0);
    for (int j = 0; j < 4; j++) host_free(j);
    send_frame(3, 8, 1, -1, 0);
    send_frame(200, 8, 0, -1, 0);
    send_frame(2, 2, 0, -1, 10);
    send_frame(2, 1, 0, 0, 0);
    send_frame(1, 7, 0, -1, 0);
    for (int it = 0; it < 40; it++) begin
      if (lowest_free() < 0) begin
        stall_check(3);
        host_free($urandom_range(0, 3));
      end
      r = $urandom_range(0, 9);
      nw = r == 0 ? $urandom_range(190, 196) : $urandom_range(1, 10);
      send_frame(nw, $urandom_range(1, 8), r == 1 && nw >= 2,
                 $urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : -1, $urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0) host_free($urandom_range(0, 3));
    end
    if (lowest_free() < 0) host_free(1);
    words = 0;
    for (int c = 0; c < 40 && words < 5; c++) begin
      @(negedge clk);
      rd_ack = 1'b1;
      rd_data = {1'b0, $urandom, $urandom, 8'hff};
      #1;
      if (rd_req) words++;
    end
    chk("pre_reset_words", words, 5);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_reset();
    @(negedge clk);
    reset = 1'b0;
    rd_ack = 1'b0;
    send_frame(3, 8, 0, -1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
